// File: rtl/xgmii_loopback_chan.sv
// XGMII loopback channel: programmable delay line between MAC TX and RX with
// one-shot byte-error injection, local-fault override and frame-start counting.
module xgmii_loopback_chan #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned LANES = DATA_W / 8,
    localparam int unsigned DW    = $clog2(DEPTH),
    localparam int unsigned LW    = $clog2(LANES)
) (
    input  logic              clk_xgmii,
    input  logic              reset_xgmii_n,
    input  logic [DATA_W-1:0] xgmii_txd,
    input  logic [LANES-1:0]  xgmii_txc,
    output logic [DATA_W-1:0] xgmii_rxd,
    output logic [LANES-1:0]  xgmii_rxc,
    input  logic [DW-1:0]     cfg_delay,
    input  logic              cfg_fault_en,
    input  logic              inj_req,
    input  logic [LW-1:0]     inj_lane,
    input  logic [7:0]        inj_mask,
    output logic              inj_busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam logic [DATA_W-1:0] IdleData = {LANES{8'h07}};
    localparam logic [LANES-1:0]  IdleCtrl = {LANES{1'b1}};
    localparam logic [DATA_W-1:0] LfData   = {(DATA_W / 32){32'h0100_009C}};
    localparam logic [LANES-1:0]  LfCtrl   = {(DATA_W / 32){4'b0001}};

    typedef enum logic [1:0] {StIdle, StArmed, StHit} inj_state_e;

    inj_state_e        inj_state_q, inj_state_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [7:0]        mask_q, mask_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [LANES-1:0]  ctrl_q [DEPTH];
    logic [LANES-1:0]  ctrl_d [DEPTH];
    logic [DATA_W-1:0] rxd_q, rxd_d;
    logic [LANES-1:0]  rxc_q, rxc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] sel_data;
    logic [LANES-1:0]  sel_ctrl;
    logic              sel_start;

    // Injection FSM; the start word that triggers is passed through untouched,
    // the word after it gets the corrupted byte.
    always_comb begin
        inj_state_d = inj_state_q;
        lane_d      = lane_q;
        mask_d      = mask_q;
        in_data     = xgmii_txd;
        unique case (inj_state_q)
            StIdle: begin
                if (inj_req) begin
                    inj_state_d = StArmed;
                    lane_d      = inj_lane;
                    mask_d      = inj_mask;
                end
            end
            StArmed: begin
                if (xgmii_txc[0] && (xgmii_txd[7:0] == 8'hFB)) begin
                    inj_state_d = StHit;
                end
            end
            StHit: begin
                in_data[{lane_q, 3'b000} +: 8] = xgmii_txd[{lane_q, 3'b000} +: 8] ^ mask_q;
                inj_state_d = StIdle;
            end
            default: inj_state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d[0] = in_data;
        ctrl_d[0] = xgmii_txc;
        for (int i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            ctrl_d[i] = ctrl_q[i-1];
        end
    end

    // Output tap, fault override and frame-start counting on the loaded word.
    always_comb begin
        sel_data  = data_q[cfg_delay];
        sel_ctrl  = ctrl_q[cfg_delay];
        sel_start = 1'b0;
        for (int k = 0; k < LANES; k += 4) begin
            if (sel_ctrl[k] && (sel_data[8*k +: 8] == 8'hFB)) begin
                sel_start = 1'b1;
            end
        end
        rxd_d = cfg_fault_en ? LfData : sel_data;
        rxc_d = cfg_fault_en ? LfCtrl : sel_ctrl;
        cnt_d = cnt_q;
        if (!cfg_fault_en && sel_start && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_xgmii) begin
        if (!reset_xgmii_n) begin
            inj_state_q <= StIdle;
            lane_q      <= '0;
            mask_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= IdleData;
                ctrl_q[i] <= IdleCtrl;
            end
            rxd_q <= IdleData;
            rxc_q <= IdleCtrl;
            cnt_q <= '0;
        end else begin
            inj_state_q <= inj_state_d;
            lane_q      <= lane_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            rxd_q       <= rxd_d;
            rxc_q       <= rxc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign xgmii_rxd = rxd_q;
    assign xgmii_rxc = rxc_q;
    assign inj_busy  = (inj_state_q != StIdle);
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_xgmii_loopback_chan.sv
// Bench for xgmii_loopback_chan: directed scenarios plus random traffic, checked
// against a history-based reference model of the loopback channel.
module tb_xgmii_loopback_chan;

    localparam logic [63:0] Idle  = 64'h0707070707070707;
    localparam logic [63:0] LfWrd = 64'h0100009C0100009C;
    localparam logic [63:0] Start = 64'hD5555555555555FB;
    localparam logic [63:0] Start4 = 64'hD5555_5FB07070707 & 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] Term  = 64'h07070707070707FD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [3:0]  cfg_delay;
    logic        fault_en;
    logic        inj_req;
    logic [2:0]  inj_lane;
    logic [7:0]  inj_mask;
    logic [63:0] rxd, rxd4;
    logic [7:0]  rxc, rxc4;
    logic        busy, busy4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [63:0] hd[$];
    logic [7:0]  hc[$];
    logic [63:0] m_rxd;
    logic [7:0]  m_rxc;
    bit          m_armed, m_hit;
    int          m_lane;
    logic [7:0]  m_mask;
    int          m_cnt, m_cnt4;

    always #5 clk = ~clk;

    xgmii_loopback_chan #(.DATA_W(64), .DEPTH(16), .CNT_W(16)) dut (
        .clk_xgmii(clk), .reset_xgmii_n(rst_n), .xgmii_txd(txd), .xgmii_txc(txc),
        .xgmii_rxd(rxd), .xgmii_rxc(rxc), .cfg_delay(cfg_delay), .cfg_fault_en(fault_en),
        .inj_req(inj_req), .inj_lane(inj_lane), .inj_mask(inj_mask), .inj_busy(busy),
        .frame_cnt(cnt)
    );

    xgmii_loopback_chan #(.DATA_W(64), .DEPTH(16), .CNT_W(4)) dut4 (
        .clk_xgmii(clk), .reset_xgmii_n(rst_n), .xgmii_txd(txd), .xgmii_txc(txc),
        .xgmii_rxd(rxd4), .xgmii_rxc(rxc4), .cfg_delay(cfg_delay), .cfg_fault_en(fault_en),
        .inj_req(inj_req), .inj_lane(inj_lane), .inj_mask(inj_mask), .inj_busy(busy4),
        .frame_cnt(cnt4)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has_start(input logic [63:0] d, input logic [7:0] c);
        return (c[0] && d[7:0] == 8'hFB) || (c[4] && d[39:32] == 8'hFB);
    endfunction

    // Advance one clock: update the model from the inputs sampled at the edge, then compare.
    task automatic step();
        logic [63:0] wd;
        logic [7:0]  wc;
        int          d;
        @(posedge clk);
        if (!rst_n) begin
            hd.delete();
            hc.delete();
            for (int i = 0; i < 16; i++) begin
                hd.push_back(Idle);
                hc.push_back(8'hFF);
            end
            m_rxd = Idle; m_rxc = 8'hFF;
            m_armed = 0; m_hit = 0; m_lane = 0; m_mask = 0;
            m_cnt = 0; m_cnt4 = 0;
        end else begin
            wd = txd;
            wc = txc;
            if (m_hit) begin
                wd[m_lane*8 +: 8] = wd[m_lane*8 +: 8] ^ m_mask;
                m_hit = 0;
            end else if (m_armed) begin
                if (wc[0] && wd[7:0] == 8'hFB) begin
                    m_armed = 0;
                    m_hit = 1;
                end
            end else if (inj_req) begin
                m_armed = 1;
                m_lane = int'(inj_lane);
                m_mask = inj_mask;
            end
            // Output is the word written cfg_delay+1 edges before this one.
            d = int'(cfg_delay);
            if (fault_en) begin
                m_rxd = LfWrd;
                m_rxc = 8'h11;
            end else begin
                m_rxd = hd[hd.size()-1-d];
                m_rxc = hc[hc.size()-1-d];
                if (has_start(m_rxd, m_rxc)) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                end
            end
            hd.push_back(wd);
            hc.push_back(wc);
            if (hd.size() > 40) begin
                void'(hd.pop_front());
                void'(hc.pop_front());
            end
        end
        #1;
        check_eq("rxd", rxd, m_rxd);
        check_eq("rxc", {56'd0, rxc}, {56'd0, m_rxc});
        check_eq("inj_busy", {63'd0, busy}, {63'd0, (m_armed || m_hit)});
        check_eq("frame_cnt", {48'd0, cnt}, 64'(m_cnt));
        check_eq("frame_cnt4", {60'd0, cnt4}, 64'(m_cnt4));
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c);
        txd = d;
        txc = c;
    endtask

    task automatic idle(input int n);
        drive(Idle, 8'hFF);
        for (int i = 0; i < n; i++) step();
    endtask

    // Start, one data word, terminate; checks the data word as it leaves (cfg_delay=0).
    task automatic frame(input bit req, input logic [63:0] dat, input logic [63:0] exp_dat);
        drive(Start, 8'h01);
        inj_req = req;
        step();
        inj_req = 1'b0;
        drive(dat, 8'h00);
        step();
        drive(Term, 8'hFF);
        step();
        check_eq("frame_data", rxd, exp_dat);
        idle(2);
    endtask

    initial begin
        int flen;
        rst_n = 1'b0; cfg_delay = '0; fault_en = 1'b0;
        inj_req = 1'b0; inj_lane = '0; inj_mask = '0;
        drive(Idle, 8'hFF);
        for (int i = 0; i < 3; i++) step();
        check_eq("reset_rxd", rxd, Idle);
        check_eq("reset_rxc", {56'd0, rxc}, 64'hFF);
        rst_n = 1'b1;
        idle(2);

        // Latency at cfg_delay 0 and 15
        drive(64'h0123456789ABCDEF, 8'h00);
        step();
        idle(1);
        check_eq("lat0_rxd", rxd, 64'h0123456789ABCDEF);
        cfg_delay = 4'd15;
        idle(20);
        drive(64'h0123456789ABCDEF, 8'h00);
        step();
        idle(15);
        check_eq("lat15_early", rxd, Idle);
        idle(1);
        check_eq("lat15_rxd", rxd, 64'h0123456789ABCDEF);
        cfg_delay = 4'd0;
        idle(20);

        // Injection on lane 2, then a clean frame
        inj_req = 1'b1; inj_lane = 3'd2; inj_mask = 8'hFF;
        step();
        inj_req = 1'b0;
        check_eq("inj_busy_set", {63'd0, busy}, 64'd1);
        frame(1'b0, 64'h1122334455667788, 64'h1122334455997788);
        check_eq("inj_busy_clr", {63'd0, busy}, 64'd0);
        frame(1'b0, 64'h1122334455667788, 64'h1122334455667788);

        // Arm coincident with a start: that frame clean, next one corrupted
        frame(1'b1, 64'h1122334455667788, 64'h1122334455667788);
        frame(1'b0, 64'h1122334455667788, 64'h1122334455997788);

        // Fault override
        fault_en = 1'b1;
        for (int i = 0; i < 2; i++) frame(1'b0, 64'hA5A5A5A5A5A5A5A5, LfWrd);
        check_eq("fault_rxc", {56'd0, rxc}, 64'h11);
        fault_en = 1'b0;
        idle(1);
        check_eq("fault_release", rxd, Idle);

        // Reset mid-frame with armed injection
        inj_req = 1'b1; inj_lane = 3'd5; inj_mask = 8'h3C;
        drive(Start, 8'h01);
        step();
        inj_req = 1'b0;
        drive(64'hCAFEF00DCAFEF00D, 8'h00);
        step();
        rst_n = 1'b0;
        step();
        check_eq("midrst_rxd", rxd, Idle);
        check_eq("midrst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        idle(3);

        // Counter: 3 lane-0 starts and 1 lane-4 start, then saturate the narrow counter
        for (int i = 0; i < 3; i++) frame(1'b0, 64'h0, 64'h0);
        drive({24'hD55555, 8'hFB, 32'h07070707}, 8'h1F);
        step();
        drive(Term, 8'hFF);
        step();
        idle(3);
        check_eq("cnt4_frames", {48'd0, cnt}, 64'd4);
        for (int i = 0; i < 20; i++) frame(1'b0, 64'h0, 64'h0);
        check_eq("cnt_sat", {60'd0, cnt4}, 64'd15);
        check_eq("cnt_wide", {48'd0, cnt}, 64'd24);

        // Random traffic
        flen = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            inj_req = 1'b0;
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                flen = 0;
            end else begin
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) fault_en = ~fault_en;
            if ($urandom_range(0, 14) == 0) begin
                inj_req = 1'b1;
                inj_lane = 3'($urandom_range(0, 7));
                inj_mask = 8'($urandom_range(1, 255));
            end
            if (flen == 0) begin
                if ($urandom_range(0, 29) == 0) cfg_delay = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 4) == 0) begin
                    flen = $urandom_range(2, 7);
                    if ($urandom_range(0, 3) == 0) drive({24'hD55555, 8'hFB, 32'h07070707}, 8'h1F);
                    else drive(Start, 8'h01);
                end else begin
                    drive(Idle, 8'hFF);
                end
            end else if (flen == 1) begin
                drive(Term, 8'hFF);
                flen = 0;
            end else begin
                drive({$urandom, $urandom}, 8'h00);
                flen--;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
